ex_mdu_stage: RTL and testbench



---
 rtl/ex_mdu_stage.sv | 215 +++++++++++++++++++++
 tb/tb_ex_mdu_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu_stage.sv
// EX stage: ALU, branch-target add, destination select and EX/MEM register, plus an iterative
// 32-step multiply unit with HI/LO. Define MDU_DIV_EN to add DIV/DIVU (restoring division).
module ex_mdu_stage #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic [3:0]  ex_ctl,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extend,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  output logic [1:0]  wb_ctlout,
  output logic [2:0]  m_ctlout,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  muxout,
  output logic        ex_stall
);

  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnSlt   = 6'h2a;
  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1a;
  localparam logic [5:0] FnDivu  = 6'h1b;

  localparam int unsigned CntW = $clog2(MUL_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StBusy} mdu_state_e;

  mdu_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]    hi_q, lo_q;
  logic [63:0]    acc_q, mcand_q;
  logic [31:0]    mplier_q, rs_q;
  logic           neg_q, rem_neg_q, div_q, dz_q;

  // Instruction decode
  logic        regdst, alusrc, is_rtype;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic        op_mfhi, op_mflo, op_mult, op_multu, op_div, op_divu, mdu_dep;
  logic        start_mul, start_div;

  assign regdst   = ex_ctl[3];
  assign aluop    = ex_ctl[2:1];
  assign alusrc   = ex_ctl[0];
  assign funct    = s_extend[5:0];
  assign is_rtype = (aluop == 2'b10);
  assign op_mfhi  = is_rtype && (funct == FnMfhi);
  assign op_mflo  = is_rtype && (funct == FnMflo);
  assign op_mult  = is_rtype && (funct == FnMult);
  assign op_multu = is_rtype && (funct == FnMultu);
  assign op_div   = is_rtype && (funct == FnDiv);
  assign op_divu  = is_rtype && (funct == FnDivu);
  assign mdu_dep  = op_mfhi | op_mflo | op_mult | op_multu | op_div | op_divu;

  // Gated by rst so a reset landing mid-BUSY never shows a stall.
  assign ex_stall  = !rst && (state_q == StBusy) && mdu_dep;
  assign start_mul = (state_q == StIdle) && (op_mult || op_multu);
`ifdef MDU_DIV_EN
  assign start_div = (state_q == StIdle) && (op_div || op_divu);
`else
  assign start_div = 1'b0;
`endif

  // ALU
  logic [31:0] op_b, alu_val;
  assign op_b = alusrc ? s_extend : rdata2;

  always_comb begin
    alu_val = '0;
    case (aluop)
      2'b00: alu_val = rdata1 + op_b;
      2'b01: alu_val = rdata1 - op_b;
      2'b10: begin
        case (funct)
          FnAdd, FnAddu: alu_val = rdata1 + op_b;
          FnSub, FnSubu: alu_val = rdata1 - op_b;
          FnAnd:         alu_val = rdata1 & op_b;
          FnOr:          alu_val = rdata1 | op_b;
          FnSlt:         alu_val = {31'd0, $signed(rdata1) < $signed(op_b)};
          FnMfhi:        alu_val = hi_q;
          FnMflo:        alu_val = lo_q;
          default:       alu_val = '0;
        endcase
      end
      default: alu_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ctlout  <= '0;
      m_ctlout   <= '0;
      add_result <= '0;
      zero       <= 1'b0;
      alu_result <= '0;
      rdata2out  <= '0;
      muxout     <= '0;
    end else begin
      wb_ctlout  <= ex_stall ? 2'b00 : wb_ctl;
      m_ctlout   <= ex_stall ? 3'b000 : m_ctl;
      add_result <= npc + {s_extend[29:0], 2'b00};
      zero       <= (alu_val == '0);
      alu_result <= alu_val;
      rdata2out  <= rdata2;
      muxout     <= regdst ? rd_in : rt_in;
    end
  end

  // MDU operand conditioning: iterate on magnitudes, fix signs at the end
  logic        signed_op, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  assign signed_op = op_mult | op_div;
  assign sign_a    = signed_op & rdata1[31];
  assign sign_b    = signed_op & rdata2[31];
  assign mag_a     = sign_a ? -rdata1 : rdata1;
  assign mag_b     = sign_b ? -rdata2 : rdata2;

  // One iteration. Division keeps the partial remainder in acc_q[31:0] and shifts the
  // dividend out of mplier_q while quotient bits shift in.
  logic [63:0] mul_acc, prod_fin;
  logic [32:0] rem_sh, rem_sub;
  logic        div_ge;
  logic [31:0] quo_next, rem_next, hi_fin, lo_fin;

  always_comb begin
    mul_acc  = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    prod_fin = neg_q ? -mul_acc : mul_acc;
    rem_sh   = {acc_q[31:0], mplier_q[31]};
    rem_sub  = rem_sh - {1'b0, mcand_q[31:0]};
    div_ge   = (rem_sh >= {1'b0, mcand_q[31:0]});
    quo_next = {mplier_q[30:0], div_ge};
    rem_next = div_ge ? rem_sub[31:0] : rem_sh[31:0];
    hi_fin   = prod_fin[63:32];
    lo_fin   = prod_fin[31:0];
    if (div_q) begin
      if (dz_q) begin
        hi_fin = rs_q;
        lo_fin = 32'hFFFF_FFFF;
      end else begin
        hi_fin = rem_neg_q ? -rem_next : rem_next;
        lo_fin = neg_q ? -quo_next : quo_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rs_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_mul || start_div) begin
            state_q   <= StBusy;
            cnt_q     <= '0;
            acc_q     <= '0;
            div_q     <= start_div;
            neg_q     <= sign_a ^ sign_b;
            rem_neg_q <= sign_a;
            dz_q      <= (rdata2 == '0);
            rs_q      <= rdata1;
            mcand_q   <= {32'd0, start_div ? mag_b : mag_a};
            mplier_q  <= start_div ? mag_a : mag_b;
          end
        end
        StBusy: begin
          if (div_q) begin
            acc_q    <= {32'd0, rem_next};
            mplier_q <= quo_next;
          end else begin
            acc_q    <= mul_acc;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            hi_q    <= hi_fin;
            lo_q    <= lo_fin;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Directed-vector bench for ex_mdu_stage; DIV vectors switch with MDU_DIV_EN.
module tb_ex_mdu_stage;

  logic        clk, rst;
  logic [1:0]  wb_ctl, wb_ctlout;
  logic [2:0]  m_ctl, m_ctlout;
  logic [3:0]  ex_ctl;
  logic [31:0] npc, rdata1, rdata2, s_extend;
  logic [4:0]  rt_in, rd_in, muxout;
  logic [31:0] add_result, alu_result, rdata2out;
  logic        zero, ex_stall;

  int n_vec = 0;
  int n_err = 0;
  int n_stall;
  logic bubble_bad;

  ex_mdu_stage #(.MUL_CYCLES(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_ctl    (wb_ctl),
    .m_ctl     (m_ctl),
    .ex_ctl    (ex_ctl),
    .npc       (npc),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .s_extend  (s_extend),
    .rt_in     (rt_in),
    .rd_in     (rd_in),
    .wb_ctlout (wb_ctlout),
    .m_ctlout  (m_ctlout),
    .add_result(add_result),
    .zero      (zero),
    .alu_result(alu_result),
    .rdata2out (rdata2out),
    .muxout    (muxout),
    .ex_stall  (ex_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_r(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    wb_ctl   = 2'b10;
    m_ctl    = 3'b010;
    ex_ctl   = 4'b1100;
    npc      = 32'h40;
    rdata1   = a;
    rdata2   = b;
    s_extend = {26'd0, fn};
    rt_in    = 5'd8;
    rd_in    = 5'd4;
  endtask

  // Counts stalled cycles (bounded) and flags any non-bubble EX/MEM output during them.
  task automatic stall_cycles(output int n);
    n = 0;
    bubble_bad = 1'b0;
    #1;
    while (ex_stall && n < 40) begin
      tick();
      n++;
      if (wb_ctlout != 2'b00 || m_ctlout != 3'b000) bubble_bad = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    wb_ctl = '0; m_ctl = '0; ex_ctl = '0; npc = '0; rdata1 = '0; rdata2 = '0;
    s_extend = '0; rt_in = '0; rd_in = '0;
    tick();
    tick();
    check("reset_stall", ex_stall, 0);
    check("reset_alu", alu_result, 0);
    check("reset_wb", wb_ctlout, 0);
    rst = 1'b0;

    // ADD
    wb_ctl = 2'b10; m_ctl = 3'b101; ex_ctl = 4'b1100; npc = 32'h4;
    rdata1 = 32'd5; rdata2 = 32'd7; s_extend = 32'h20; rt_in = 5'd9; rd_in = 5'd3;
    #1 check("add_stall", ex_stall, 0);
    tick();
    check("add_alu", alu_result, 32'd12);
    check("add_zero", zero, 0);
    check("add_mux", muxout, 5'd3);
    check("add_wb", wb_ctlout, 2'b10);
    check("add_m", m_ctlout, 3'b101);
    check("add_rd2", rdata2out, 32'd7);

    // BEQ
    wb_ctl = 2'b00; m_ctl = 3'b100; ex_ctl = 4'b0010; npc = 32'h100;
    rdata1 = 32'd9; rdata2 = 32'd9; s_extend = 32'd4; rt_in = 5'd6;
    tick();
    check("beq_zero", zero, 1);
    check("beq_target", add_result, 32'h110);
    check("beq_mux", muxout, 5'd6);

    // ADDI with negative immediate
    wb_ctl = 2'b10; m_ctl = 3'b000; ex_ctl = 4'b0001; rdata1 = 32'd10; s_extend = 32'hFFFF_FFFF;
    npc = 32'h10;
    tick();
    check("addi_alu", alu_result, 32'd9);
    check("addi_target", add_result, 32'hC);

    set_r(6'h2a, 32'hFFFF_FFFF, 32'd1); tick(); check("slt", alu_result, 32'd1);
    set_r(6'h24, 32'hF0F0, 32'hFF00);   tick(); check("and", alu_result, 32'hF000);
    set_r(6'h25, 32'hF0F0, 32'h0F0F);   tick(); check("or", alu_result, 32'hFFFF);
    set_r(6'h23, 32'd3, 32'd5);         tick(); check("subu", alu_result, 32'hFFFF_FFFE);
    set_r(6'h3f, 32'd3, 32'd5);         tick(); check("bad_funct", alu_result, 32'd0);

    // MULT -3 * 7, MFLO right behind it
    set_r(6'h18, 32'hFFFF_FFFD, 32'd7);
    #1 check("mult_issue_stall", ex_stall, 0);
    tick();
    set_r(6'h12, 32'd0, 32'd0);
    stall_cycles(n_stall);
    check("mflo_stall_len", n_stall, 32);
    check("mflo_bubble", bubble_bad, 0);
    tick();
    check("mult_lo", alu_result, 32'hFFFF_FFEB);
    check("mflo_wb", wb_ctlout, 2'b10);
    set_r(6'h10, 32'd0, 32'd0); #1 check("idle_mfhi_stall", ex_stall, 0);
    tick();
    check("mult_hi", alu_result, 32'hFFFF_FFFF);

    // MULTU, independent ADD while busy, then MFHI/MFLO
    set_r(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    set_r(6'h20, 32'd1, 32'd2);
    #1 check("busy_add_stall", ex_stall, 0);
    tick();
    check("busy_add_alu", alu_result, 32'd3);
    check("busy_add_wb", wb_ctlout, 2'b10);
    set_r(6'h10, 32'd0, 32'd0);
    stall_cycles(n_stall);
    check("mfhi_stall_len", n_stall, 31);
    tick();
    check("multu_hi", alu_result, 32'hFFFF_FFFE);
    set_r(6'h12, 32'd0, 32'd0); tick();
    check("multu_lo", alu_result, 32'h0000_0001);

    // MULT back to back
    set_r(6'h18, 32'd2, 32'd3);
    tick();
    set_r(6'h18, 32'd4, 32'd5);
    stall_cycles(n_stall);
    check("mult2_stall_len", n_stall, 32);
    tick();
    set_r(6'h12, 32'd0, 32'd0);
    stall_cycles(n_stall);
    check("mult2_mflo_stall", n_stall, 32);
    tick();
    check("mult2_lo", alu_result, 32'd20);

    // Reset in cycle T+10 of a MULT
    set_r(6'h18, 32'd6, 32'd7);
    tick();
    set_r(6'h20, 32'd1, 32'd1);
    repeat (9) tick();
    set_r(6'h12, 32'd0, 32'd0);
    rst = 1'b1;
    #1 check("rst_busy_stall", ex_stall, 0);
    tick();
    rst = 1'b0;
    #1 check("post_rst_stall", ex_stall, 0);
    check("post_rst_alu", alu_result, 0);
    check("post_rst_wb", wb_ctlout, 0);
    check("post_rst_m", m_ctlout, 0);
    check("post_rst_target", add_result, 0);
    check("post_rst_mux", muxout, 0);
    check("post_rst_rd2", rdata2out, 0);
    tick();
    check("post_rst_lo", alu_result, 0);
    check("post_rst_zero", zero, 1);
    set_r(6'h10, 32'd0, 32'd0); tick();
    check("post_rst_hi", alu_result, 0);

`ifdef MDU_DIV_EN
    set_r(6'h1a, 32'hFFFF_FFF9, 32'd2);
    tick();
    set_r(6'h12, 32'd0, 32'd0);
    stall_cycles(n_stall);
    check("div_stall_len", n_stall, 32);
    tick();
    check("div_lo", alu_result, 32'hFFFF_FFFD);
    set_r(6'h10, 32'd0, 32'd0); tick();
    check("div_hi", alu_result, 32'hFFFF_FFFF);

    set_r(6'h1b, 32'd5, 32'd0);
    tick();
    set_r(6'h12, 32'd0, 32'd0);
    stall_cycles(n_stall);
    check("divu0_stall_len", n_stall, 32);
    tick();
    check("divu0_lo", alu_result, 32'hFFFF_FFFF);
    set_r(6'h10, 32'd0, 32'd0); tick();
    check("divu0_hi", alu_result, 32'd5);
`else
    // Set LO=15, HI=0, then confirm DIV neither starts nor touches HI/LO
    set_r(6'h19, 32'd3, 32'd5);
    tick();
    set_r(6'h12, 32'd0, 32'd0);
    stall_cycles(n_stall);
    tick();
    check("pre_div_lo", alu_result, 32'd15);
    set_r(6'h1a, 32'hFFFF_FFF9, 32'd2);
    #1 check("nodiv_stall", ex_stall, 0);
    tick();
    check("nodiv_alu", alu_result, 0);
    set_r(6'h12, 32'd0, 32'd0);
    #1 check("nodiv_mflo_stall", ex_stall, 0);
    tick();
    check("nodiv_lo", alu_result, 32'd15);
    set_r(6'h10, 32'd0, 32'd0); tick();
    check("nodiv_hi", alu_result, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
